// File: rtl/jpeg_coef_block_builder_if.sv
// rtl/jpeg_coef_block_builder_if.sv - symbol and block handshake bundle for jpeg_coef_block_builder
interface jpeg_coef_block_builder_if #(
    parameter int WIDTH = 16
);
    logic                  sym_valid;
    logic                  sym_ready;
    logic [3:0]            sym_run;
    logic [WIDTH-1:0]      sym_level;
    logic                  sym_eob;
    logic                  blk_valid;
    logic                  blk_ready;
    logic [WIDTH*64-1:0]   zz_out_flat;
    logic                  blk_err;
    logic                  dc_restart;

    modport master (
        output sym_valid, sym_run, sym_level, sym_eob, blk_ready, dc_restart,
        input  sym_ready, blk_valid, zz_out_flat, blk_err
    );

    modport slave (
        input  sym_valid, sym_run, sym_level, sym_eob, blk_ready, dc_restart,
        output sym_ready, blk_valid, zz_out_flat, blk_err
    );
endinterface

// File: rtl/jpeg_coef_block_builder.sv
// rtl/jpeg_coef_block_builder.sv - run/level symbols to 64-coefficient zigzag block assembler
// Optional differential DC decode enabled by defining JPEG_DC_PRED_EN.
module jpeg_coef_block_builder #(
    parameter int WIDTH     = 16,
    parameter int BLOCK_LEN = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    jpeg_coef_block_builder_if.slave    bus
);
    typedef enum logic {FILL, OUT} state_t;

    state_t           state;
    logic [WIDTH-1:0] coef [BLOCK_LEN];
    logic [6:0]       idx;
    logic             blk_err_q;
    logic             sym_ready_q;
    logic             blk_valid_q;
    logic [6:0]       pos;
    logic [WIDTH-1:0] wr_val;
    logic             sym_acc;

    assign sym_acc = bus.sym_valid && sym_ready_q;
    // idx never exceeds 63 while filling, so idx+15 still fits in 7 bits
    assign pos     = idx + {3'b000, bus.sym_run};

`ifdef JPEG_DC_PRED_EN
    logic [WIDTH-1:0] dc_pred;
    assign wr_val = (idx == 7'd0) ? dc_pred + bus.sym_level : bus.sym_level;
`else
    assign wr_val = bus.sym_level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            idx         <= 7'd0;
            blk_err_q   <= 1'b0;
            sym_ready_q <= 1'b1;
            blk_valid_q <= 1'b0;
            for (int k = 0; k < BLOCK_LEN; k++) coef[k] <= '0;
`ifdef JPEG_DC_PRED_EN
            dc_pred     <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (sym_acc) begin
                        if (bus.sym_eob) begin
`ifdef JPEG_DC_PRED_EN
                            if (idx == 7'd0) coef[0] <= dc_pred;
`endif
                            state       <= OUT;
                            sym_ready_q <= 1'b0;
                            blk_valid_q <= 1'b1;
                        end else if (pos > 7'd63) begin
                            blk_err_q   <= 1'b1;
                            state       <= OUT;
                            sym_ready_q <= 1'b0;
                            blk_valid_q <= 1'b1;
                        end else begin
                            coef[pos[5:0]] <= wr_val;
                            idx            <= pos + 7'd1;
                            if (pos == 7'd63) begin
                                state       <= OUT;
                                sym_ready_q <= 1'b0;
                                blk_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                OUT: begin
                    if (bus.blk_ready) begin
                        for (int k = 0; k < BLOCK_LEN; k++) coef[k] <= '0;
                        idx         <= 7'd0;
                        blk_err_q   <= 1'b0;
                        state       <= FILL;
                        sym_ready_q <= 1'b1;
                        blk_valid_q <= 1'b0;
`ifdef JPEG_DC_PRED_EN
                        dc_pred     <= coef[0];
`endif
                    end
                end
            endcase
`ifdef JPEG_DC_PRED_EN
            // restart placed last so it overrides a coincident handshake update
            if (bus.dc_restart) dc_pred <= '0;
`endif
        end
    end

    assign bus.sym_ready = sym_ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_err   = blk_err_q;

    for (genvar g = 0; g < BLOCK_LEN; g++) begin : g_flat
        assign bus.zz_out_flat[WIDTH*g +: WIDTH] = coef[g];
    end
endmodule

// File: tb/tb_jpeg_coef_block_builder.sv
// tb/tb_jpeg_coef_block_builder.sv - scoreboard bench for jpeg_coef_block_builder
module tb_jpeg_coef_block_builder;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jpeg_coef_block_builder_if #(.WIDTH(W)) bus ();

    jpeg_coef_block_builder #(.WIDTH(W), .BLOCK_LEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W*64-1:0] data;
        logic            err;
    } exp_t;

    exp_t            sb[$];
    logic [W-1:0]    m_coef [64];
    int              m_idx;
    logic            m_err;
    logic [W-1:0]    m_pred;
    logic            m_done;
    int              checks   = 0;
    int              failures = 0;
    logic [W*64-1:0] snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_coef(input string tag, input int k, input logic [W-1:0] exp);
        logic [W-1:0] obs;
        obs = bus.zz_out_flat[W*k +: W];
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s coef[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [W*64-1:0] obs, input logic [W*64-1:0] exp);
        int first;
        first = -1;
        for (int k = 63; k >= 0; k--)
            if (obs[W*k +: W] !== exp[W*k +: W]) first = k;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s first bad coef[%0d] observed=%0h expected=%0h",
                   tag, first, obs[W*first +: W], exp[W*first +: W]);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 64; k++) m_coef[k] = '0;
        m_idx = 0;
        m_err = 1'b0;
    endtask

    task automatic model_complete();
        exp_t e;
        for (int k = 0; k < 64; k++) e.data[W*k +: W] = m_coef[k];
        e.err = m_err;
        sb.push_back(e);
        model_clear();
        m_done = 1'b1;
    endtask

    task automatic send(input logic [3:0] run, input logic [W-1:0] level, input logic eob);
        int n;
        int pos;
        n      = 0;
        m_done = 1'b0;
        @(negedge clk);
        while (!bus.sym_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", bus.sym_ready, 1);
        bus.sym_valid = 1'b1;
        bus.sym_run   = run;
        bus.sym_level = level;
        bus.sym_eob   = eob;
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
        if (eob) begin
`ifdef JPEG_DC_PRED_EN
            if (m_idx == 0) m_coef[0] = m_pred;
`endif
            model_complete();
        end else begin
            pos = m_idx + int'(run);
            if (pos > 63) begin
                m_err = 1'b1;
                model_complete();
            end else begin
`ifdef JPEG_DC_PRED_EN
                m_coef[pos] = (m_idx == 0) ? m_pred + level : level;
`else
                m_coef[pos] = level;
`endif
                m_idx = pos + 1;
                if (m_idx == 64) model_complete();
            end
        end
        if (m_done) begin
            chk("lat_blk_valid", bus.blk_valid, 1);
            chk("lat_sym_ready", bus.sym_ready, 0);
        end
    endtask

    task automatic get_block(input string tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.blk_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.blk_valid, 1);
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_blk({tag, "_data"}, bus.zz_out_flat, e.data);
            chk({tag, "_err"}, bus.blk_err, e.err);
            m_pred = e.data[W-1:0];
        end
        bus.blk_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.blk_ready = 1'b0;
        chk({tag, "_post_sym_ready"}, bus.sym_ready, 1);
        chk({tag, "_post_blk_valid"}, bus.blk_valid, 0);
    endtask

    task automatic restart_dc();
        @(negedge clk);
        bus.dc_restart = 1'b1;
        @(posedge clk);
        #1;
        bus.dc_restart = 1'b0;
        m_pred = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.sym_valid  = 1'b0;
        bus.sym_run    = 4'd0;
        bus.sym_level  = '0;
        bus.sym_eob    = 1'b0;
        bus.blk_ready  = 1'b0;
        bus.dc_restart = 1'b0;
        m_pred         = '0;
        m_done         = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sym_ready", bus.sym_ready, 1);
        chk("rst_blk_valid", bus.blk_valid, 0);
        chk("rst_blk_err", bus.blk_err, 0);
        chk("rst_zz_zero", (bus.zz_out_flat == '0), 1);

        // runs and levels closed by EOB
        restart_dc();
        send(4'd0, 16'sd50, 1'b0);
        send(4'd2, -16'sd3, 1'b0);
        send(4'd0, 16'sd7, 1'b0);
        send(4'd0, 16'sd0, 1'b1);
        chk_coef("t1", 0, 16'sd50);
        chk_coef("t1", 1, 16'sd0);
        chk_coef("t1", 2, 16'sd0);
        chk_coef("t1", 3, -16'sd3);
        chk_coef("t1", 4, 16'sd7);
        chk_coef("t1", 5, 16'sd0);
        get_block("t1");

        // full block without EOB
        restart_dc();
        for (int k = 0; k < 64; k++) send(4'd0, 16'(k + 1), 1'b0);
        chk_coef("t2", 0, 16'd1);
        chk_coef("t2", 63, 16'd64);
        get_block("t2");

        // ZRL chain running past index 63
        restart_dc();
        send(4'd0, 16'sd5, 1'b0);
        for (int k = 0; k < 4; k++) send(4'd15, 16'sd0, 1'b0);
        chk("t3_err", bus.blk_err, 1);
        chk_coef("t3", 0, 16'sd5);
        chk_coef("t3", 16, 16'sd0);
        get_block("t3");

        // downstream stall with a symbol pending
        restart_dc();
        send(4'd0, 16'sd11, 1'b0);
        send(4'd1, 16'sd22, 1'b0);
        send(4'd0, 16'sd0, 1'b1);
        snap          = bus.zz_out_flat;
        bus.sym_valid = 1'b1;
        bus.sym_run   = 4'd0;
        bus.sym_level = 16'sd99;
        bus.sym_eob   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_stall_valid", bus.blk_valid, 1);
            chk("t4_stall_ready", bus.sym_ready, 0);
            chk_blk("t4_stall_data", bus.zz_out_flat, snap);
        end
        bus.sym_valid = 1'b0;
        get_block("t4");
        restart_dc();
        send(4'd0, 16'sd0, 1'b1);
        chk("t4_no_leak", (bus.zz_out_flat == '0), 1);
        get_block("t4b");

        // reset in the middle of a block
        send(4'd0, 16'sd9, 1'b0);
        send(4'd3, 16'sd4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        m_pred = '0;
        chk("t5_sym_ready", bus.sym_ready, 1);
        chk("t5_blk_valid", bus.blk_valid, 0);
        send(4'd0, 16'sd0, 1'b1);
        chk("t5_zero_blk", (bus.zz_out_flat == '0), 1);
        get_block("t5");

        // DC difference sequence
        restart_dc();
        send(4'd0, 16'sd10, 1'b0);
        send(4'd0, 16'sd0, 1'b1);
        chk_coef("t6_a", 0, 16'sd10);
        get_block("t6_a");
        send(4'd0, -16'sd4, 1'b0);
        send(4'd0, 16'sd0, 1'b1);
`ifdef JPEG_DC_PRED_EN
        chk_coef("t6_b", 0, 16'sd6);
`else
        chk_coef("t6_b", 0, -16'sd4);
`endif
        get_block("t6_b");
        restart_dc();
        send(4'd0, 16'sd3, 1'b0);
        send(4'd0, 16'sd0, 1'b1);
        chk_coef("t6_c", 0, 16'sd3);
        get_block("t6_c");

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jpeg_coef_block_builder.md
Name: jpeg_coef_block_builder

Overview:
Run/level-to-block assembler placed directly upstream of jpeg_transform_block. Consumes entropy-decoded symbols (zero-run, level, EOB) one per cycle over a valid/ready handshake. Builds one 64-coefficient block in zigzag order. Presents the block as a flat vector that drives the transform stage's zig-zag coefficient input, using a second valid/ready handshake.

Parameters:
WIDTH, 16, coefficient/level width in bits (signed); matches the transform stage's input width.
BLOCK_LEN, 64, coefficients per block; fixed at 64, not for override.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
sym_valid  input  1  symbol present
sym_ready  output  1  builder accepts symbol this cycle
sym_run  input  4  zero-run preceding the level (0..15)
sym_level  input  WIDTH  signed level written after the run
sym_eob  input  1  end-of-block marker; sym_run/sym_level ignored when set
blk_valid  output  1  complete block held on zz_out_flat
blk_ready  input  1  downstream accepts block
zz_out_flat  output  WIDTH*64  coefficient k at bits [WIDTH*k +: WIDTH], zigzag order, k=0 is DC
blk_err  output  1  current block overflowed (run past index 63)
dc_restart  input  1  clears DC predictor (used only with JPEG_DC_PRED_EN; ignored otherwise)

Behaviour:
- All behaviour is synchronous to the rising edge of clk. rst high on any edge has top priority, including in the middle of a block. Reset sets:
  - state=FILL, idx=0
  - all 64 coefficient registers = 0
  - blk_valid=0, blk_err=0, DC predictor=0
- State machine:
  - FILL: sym_ready=1, blk_valid=0.
  - OUT: sym_ready=0, blk_valid=1. zz_out_flat and blk_err are stable until the block handshake.
- Symbol accept = sym_valid && sym_ready.
- Write index idx is 7 bits wide, 0..64.
- Level symbol (sym_eob=0):
  - pos = idx + sym_run, computed in 7 bits.
  - If pos <= 63: coef[pos] = sym_level; idx = pos+1.
  - ZRL (run=15, level=0) needs no special case; it writes 0 and advances idx by 16.
- Block completion, taking effect on the accept edge:
  - sym_eob=1 with any idx: block complete.
  - A level write that makes idx = 64: block complete, no EOB required.
  - Positions skipped by runs or after EOB remain 0, because the buffer is all-zero at the start of each block.
- Overflow: level symbol with pos > 63:
  - Level is discarded.
  - blk_err is set.
  - Block completes immediately; no further symbols are consumed for that block.
- EOB with idx=0 emits an all-zero block. This is legal.
- Latency: blk_valid rises the cycle after the completing symbol is accepted.
- Throughput: 1 symbol/cycle in FILL. 1 idle cycle minimum between blocks (the OUT state).
- Block handshake = blk_valid && blk_ready. On that edge:
  - all coef registers are cleared to 0
  - idx=0, blk_err=0, state=FILL
  - the next cycle accepts symbols.
- Handshake independence:
  - A symbol offered while in OUT is not consumed.
  - sym_valid and blk_ready have no combinational path to each other's ready/valid.
- Output timing: zz_out_flat is a direct register output with no combinational path from inputs.
- blk_valid must stay asserted, and data stable, while blk_ready=0 (stall for any number of cycles).

Optional Feature:
JPEG_DC_PRED_EN: differential DC decode inside the builder.
- With the macro defined:
  - The first level symbol of each block must have run=0; it is treated as the DC difference.
  - coef[0] = dc_pred + sym_level, truncated to WIDTH bits, two's complement wrap.
  - dc_pred is updated to that value when the block handshake completes.
  - dc_restart=1 in any cycle sets dc_pred=0. When it coincides with a block handshake, the restart wins.
  - A block closed by EOB with idx=0 uses coef[0] = dc_pred.
- Without the macro:
  - sym_level is stored to coef[0] verbatim.
  - dc_restart is unconnected internally.
  - No predictor register exists.

Test Plan:
- Reset, then symbols (0,+50),(2,-3),(0,+7),EOB -> blk_valid one cycle after EOB accept; coef0=50, coef1=0, coef2=0, coef3=-3, coef4=7, coef5..63=0; blk_err=0.
- 64 symbols with run=0, level=k+1 for k=0..63, no EOB -> block completes on the 64th accept; coef[k]=k+1; sym_ready low the next cycle.
- Symbols (0,5),(15,0),(15,0),(15,0),(15,0) -> the 5th symbol has pos=64, so blk_err=1 and the block emits with coef0=5, coef16=0, and all others 0.
- blk_ready held low 10 cycles while blk_valid=1 and sym_valid=1 -> no symbol consumed, zz_out_flat unchanged. On release the buffer clears and the next block starts clean; coefs from the previous block must not leak.
- rst asserted mid-block after (0,9),(3,4) -> next cycle sym_ready=1, blk_valid=0; a following EOB yields an all-zero block.
- With JPEG_DC_PRED_EN: blocks with DC diffs +10, -4, then dc_restart, then +3 -> coef0 = 10, 6, 3 respectively.
